// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a non-showahead fifo into a framed valid/ready stream with decimation
module fifo_stream_reader #(
  parameter int DWIDTH    = 8,
  parameter int SWIDTH    = 2,
  parameter int FRAME_LEN = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [SWIDTH-1:0] decim_i,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_rddata_i,
  output logic              fifo_rd_o,
  output logic [SWIDTH-1:0] fifo_shift_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o
);
  localparam int CW = $clog2(FRAME_LEN);
  typedef enum logic [1:0] {IDLE, RUN, FINISH, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] cnt, cnt_nx;
  logic in_flight, in_tag, pop, push, at_last;
  logic [1:0] fill;
  logic [2:0] occ;
  logic [DWIDTH:0] skid0, skid1, word;
  assign pop = m_valid_o & m_ready_i;
  assign push = in_flight;
  assign word = {in_tag, fifo_rddata_i};
  assign at_last = cnt == CW'(FRAME_LEN - 1);
  // occupancy counts the word leaving this cycle so a held-high ready sustains one word per cycle
  assign occ = {1'b0, fill} + {2'b0, in_flight} - {2'b0, pop};
  assign fifo_rd_o = (state == RUN || state == FINISH) && !fifo_empty_i && occ < 3'd2;
  assign cnt_nx = fifo_rd_o ? (at_last ? '0 : cnt + 1'b1) : cnt;
  assign m_valid_o = fill != 2'd0;
  assign m_data_o = skid0[DWIDTH-1:0];
  assign m_last_o = skid0[DWIDTH] & m_valid_o;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      in_flight <= 1'b0;
      in_tag <= 1'b0;
      fill <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
      fifo_shift_o <= SWIDTH'(1);
    end else begin
      in_flight <= fifo_rd_o;
      if (fifo_rd_o) in_tag <= at_last;
      cnt <= cnt_nx;
      if (pop) skid0 <= (push && fill == 2'd1) ? word : skid1;
      else if (push && fill == 2'd0) skid0 <= word;
      if (push && (pop ? fill == 2'd2 : fill == 2'd1)) skid1 <= word;
      fill <= fill + {1'b0, push} - {1'b0, pop};
      case (state)
        IDLE: if (start_i) begin
          state <= RUN;
          cnt <= '0;
          fifo_shift_o <= (decim_i == '0) ? SWIDTH'(1) : decim_i;
        end
        RUN: if (stop_i) state <= (cnt_nx == '0) ? DRAIN : FINISH;
        FINISH: if (cnt_nx == '0) state <= DRAIN;
        DRAIN: if (fill == 2'd0 && !in_flight) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
